// File: rtl/arb_req_pkg.sv
// Shared types and helpers for the round-robin requester front end.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
// Contents: slot_cnt_t (per-client slot occupancy), onehot0(), onehot_to_idx().
// Vector helpers take up to MAX_VEC_W bits; callers zero-extend narrower vectors.
package arb_req_pkg;

   localparam int MAX_VEC_W = 32;
   localparam int MAX_IDX_W = 5;

   // Occupancy of a two-entry client slot, range 0..2.
   typedef logic [1:0] slot_cnt_t;

   localparam slot_cnt_t SLOT_DEPTH = 2'd2;

   // True when at most one bit is set.
   function automatic bit onehot0(input logic [MAX_VEC_W-1:0] vec);
      return (vec & (vec - MAX_VEC_W'(1))) == '0;
   endfunction

   // Index of the set bit of a one-hot vector (OR of indices, so 0 for a zero vector).
   function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_VEC_W-1:0] vec);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_VEC_W; i++) begin
         if (vec[i]) idx |= MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/req_slot_fifo.sv
// Two-entry FIFO holding one client's pending payloads.
// Latency: push visible at head/count the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clock, reset (sync, active-high); push_i/push_data_i write side;
//        pop_i read side; count_o, head_o, full_o, empty_o status.
module req_slot_fifo
   import arb_req_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output slot_cnt_t         count_o,
   output logic [DATA_W-1:0] head_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [2];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   slot_cnt_t         count_q, count_d;
   logic              do_push, do_pop;

   assign full_o  = (count_q == SLOT_DEPTH);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A full slot never accepts, even when it is being popped this cycle.
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      if (do_push && !do_pop)      count_d = count_q + 2'd1;
      else if (do_pop && !do_push) count_d = count_q - 2'd1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset: count gates what is ever read out.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/arb_requester.sv
// Client-side front end of the round-robin request/grant protocol.
// Latency: 1 cycle from accepted grant to out_valid/out_data/out_client.
// Backpressure: output register holds while out_valid & ~out_ready; stall tells the arbiter to stop granting.
// Ports: clock, reset (sync, active-high); in_valid/in_ready/in_data per-client producers;
//        request/grant/stall to the arbiter; out_valid/out_ready/out_data/out_client downstream;
//        grant_err protocol-violation pulse; starve_err sticky per-client starvation flags.
// Optional: ARB_REQ_STARVE_CHECK_EN enables per-client wait counters behind starve_err.
module arb_requester
   import arb_req_pkg::*;
#(
   parameter  int CLIENTS  = 8,
   parameter  int DATA_W   = 32,
   parameter  int MAX_WAIT = 64,
   localparam int CLIENT_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CLIENTS-1:0]        in_valid,
   output logic [CLIENTS-1:0]        in_ready,
   input  logic [CLIENTS*DATA_W-1:0] in_data,
   output logic [CLIENTS-1:0]        request,
   input  logic [CLIENTS-1:0]        grant,
   output logic                      stall,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [CLIENT_W-1:0]       out_client,
   output logic                      grant_err,
   output logic [CLIENTS-1:0]        starve_err
);

   slot_cnt_t         slot_cnt  [CLIENTS];
   logic [DATA_W-1:0] slot_head [CLIENTS];
   logic [CLIENTS-1:0] slot_full, slot_empty, slot_push, slot_pop;

   // Low for the first cycle after reset so in_ready comes only from registered state.
   logic rst_done_q;

   logic                grant_any, grant_bad, grant_ok;
   logic [CLIENT_W-1:0] grant_idx;

   logic                out_valid_q,  out_valid_d;
   logic [DATA_W-1:0]   out_data_q,   out_data_d;
   logic [CLIENT_W-1:0] out_client_q, out_client_d;
   logic                grant_err_q,  grant_err_d;

   for (genvar g = 0; g < CLIENTS; g++) begin : g_slot
      req_slot_fifo #(.DATA_W(DATA_W)) u_slot (
         .clock       (clock),
         .reset       (reset),
         .push_i      (slot_push[g]),
         .push_data_i (in_data[g*DATA_W +: DATA_W]),
         .pop_i       (slot_pop[g]),
         .count_o     (slot_cnt[g]),
         .head_o      (slot_head[g]),
         .full_o      (slot_full[g]),
         .empty_o     (slot_empty[g])
      );

      assign request[g]   = (slot_cnt[g] != '0);
      assign in_ready[g]  = rst_done_q & ~slot_full[g];
      assign slot_push[g] = in_valid[g] & in_ready[g];
      // request already implies non-empty; the empty term keeps the pop self-evidently safe.
      assign slot_pop[g]  = grant_ok & grant[g] & ~slot_empty[g];
   end

   always_ff @(posedge clock) begin
      if (reset) rst_done_q <= 1'b0;
      else       rst_done_q <= 1'b1;
   end

   assign stall = out_valid_q & ~out_ready;

   // A violating grant (multi-hot, to an idle client, or during stall) is dropped whole.
   assign grant_any = |grant;
   assign grant_bad = grant_any &
                      (~onehot0(MAX_VEC_W'(grant)) | (|(grant & ~request)) | stall);
   assign grant_ok  = grant_any & ~grant_bad;
   assign grant_idx = CLIENT_W'(onehot_to_idx(MAX_VEC_W'(grant)));

   // A dropped grant does not load the register, but a pending beat still drains normally.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_client_d = out_client_q;
      grant_err_d  = grant_bad;
      if (grant_ok) begin
         out_valid_d  = 1'b1;
         out_data_d   = slot_head[grant_idx];
         out_client_d = grant_idx;
      end else if (out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_client_q <= '0;
         grant_err_q  <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_client_q <= out_client_d;
         grant_err_q  <= grant_err_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_client = out_client_q;
   assign grant_err  = grant_err_q;

`ifdef ARB_REQ_STARVE_CHECK_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0]  wait_q [CLIENTS];
   logic [WAIT_W-1:0]  wait_d [CLIENTS];
   logic [CLIENTS-1:0] starve_q, starve_d;

   // Counts consecutive cycles of an ungranted request; any grant bit on the
   // client (even one that is rejected) restarts the count.
   always_comb begin
      for (int i = 0; i < CLIENTS; i++) begin
         wait_d[i]   = wait_q[i];
         starve_d[i] = starve_q[i];
         if (grant[i] || !request[i]) wait_d[i] = '0;
         else if (wait_q[i] != WAIT_W'(MAX_WAIT)) wait_d[i] = wait_q[i] + WAIT_W'(1);
         if (wait_d[i] == WAIT_W'(MAX_WAIT)) starve_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < CLIENTS; i++) wait_q[i] <= '0;
         starve_q <= '0;
      end else begin
         for (int i = 0; i < CLIENTS; i++) wait_q[i] <= wait_d[i];
         starve_q <= starve_d;
      end
   end

   assign starve_err = starve_q;
`else
   assign starve_err = '0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;

   localparam int CLIENTS = 8;
   localparam int DATA_W  = 32;
   localparam int CW      = 3;
`ifdef ARB_REQ_STARVE_CHECK_EN
   localparam int MAX_WAIT = 4;
`else
   localparam int MAX_WAIT = 64;
`endif

   logic                      clock = 1'b0;
   logic                      reset = 1'b1;
   logic [CLIENTS-1:0]        in_valid = '0;
   logic [CLIENTS-1:0]        in_ready;
   logic [CLIENTS*DATA_W-1:0] in_data = '0;
   logic [CLIENTS-1:0]        request;
   logic [CLIENTS-1:0]        grant = '0;
   logic                      stall;
   logic                      out_valid;
   logic                      out_ready = 1'b0;
   logic [DATA_W-1:0]         out_data;
   logic [CW-1:0]             out_client;
   logic                      grant_err;
   logic [CLIENTS-1:0]        starve_err;

   always #5 clock = ~clock;

   arb_requester #(.CLIENTS(CLIENTS), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .request    (request),
      .grant      (grant),
      .stall      (stall),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_client (out_client),
      .grant_err  (grant_err),
      .starve_err (starve_err)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: per-client two-entry queues, output-register occupancy,
   // pending error pulse, and the scoreboard of beats still owed downstream.
   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [CW-1:0]     c;
   } exp_t;

   int                m_cnt [CLIENTS];
   logic [DATA_W-1:0] m_e0  [CLIENTS];
   logic [DATA_W-1:0] m_e1  [CLIENTS];
   bit                m_full, m_ready_en, m_err;
   int                m_wait [CLIENTS];
   logic [CLIENTS-1:0] m_starve;
   exp_t              sb [$];

   function automatic logic [CLIENTS-1:0] m_req();
      logic [CLIENTS-1:0] r;
      for (int i = 0; i < CLIENTS; i++) r[i] = (m_cnt[i] != 0);
      return r;
   endfunction

   function automatic logic [CLIENTS*DATA_W-1:0] dat1(input int c, input logic [DATA_W-1:0] d);
      logic [CLIENTS*DATA_W-1:0] v;
      v = '0;
      v[c*DATA_W +: DATA_W] = d;
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < CLIENTS; i++) begin
         m_cnt[i] = 0; m_e0[i] = '0; m_e1[i] = '0; m_wait[i] = 0;
      end
      m_full = 0; m_ready_en = 0; m_err = 0; m_starve = '0;
      sb.delete();
   endtask

   // One clock cycle: entered and left at posedge+1.
   task automatic step(input logic [CLIENTS-1:0] vld, input logic [CLIENTS*DATA_W-1:0] dat,
                       input logic [CLIENTS-1:0] gnt, input logic ordy);
      logic [CLIENTS-1:0] req, rdy;
      bit ok, stl;
      exp_t e;
      req = m_req();
      for (int i = 0; i < CLIENTS; i++) rdy[i] = m_ready_en && (m_cnt[i] < 2);
      chk("request", request, req);
      chk("in_ready", in_ready, rdy);
      chk("out_valid", out_valid, m_full);
      chk("grant_err", grant_err, m_err);
`ifdef ARB_REQ_STARVE_CHECK_EN
      chk("starve_err", starve_err, m_starve);
`else
      chk("starve_err_off", starve_err, '0);
`endif
      in_valid  = vld;
      in_data   = dat;
      grant     = gnt;
      out_ready = ordy;
      #1;
      stl = m_full && !ordy;
      chk("stall", stall, stl);
      ok    = (gnt != 0) && ($countones(gnt) == 1) && ((gnt & ~req) == 0) && !stl;
      m_err = (gnt != 0) && !ok;
      for (int i = 0; i < CLIENTS; i++) begin
         if (req[i] && !gnt[i]) m_wait[i] = (m_wait[i] < MAX_WAIT) ? m_wait[i] + 1 : MAX_WAIT;
         else                   m_wait[i] = 0;
         if (m_wait[i] == MAX_WAIT) m_starve[i] = 1'b1;
         if (ok && gnt[i]) begin
            e.d = m_e0[i];
            e.c = CW'(i);
            sb.push_back(e);
            m_e0[i] = m_e1[i];
            m_cnt[i]--;
         end
         if (vld[i] && rdy[i]) begin
            if (m_cnt[i] == 0) m_e0[i] = dat[i*DATA_W +: DATA_W];
            else               m_e1[i] = dat[i*DATA_W +: DATA_W];
            m_cnt[i]++;
         end
      end
      m_full     = ok ? 1'b1 : (m_full && !ordy);
      m_ready_en = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1; in_valid = '0; grant = '0; out_ready = 1'b0;
      repeat (cycles) @(posedge clock);
      #1;
      chk("rst_request", request, '0);
      chk("rst_in_ready", in_ready, '0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_client", out_client, 0);
      chk("rst_grant_err", grant_err, 0);
      chk("rst_starve_err", starve_err, '0);
      model_clear();
      reset = 1'b0;
   endtask

   // Monitor: every downstream handshake must match the oldest owed beat,
   // and a held beat must not change.
   bit                hold_prev = 0;
   logic [DATA_W-1:0] prev_data;
   logic [CW-1:0]     prev_client;

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            hold_prev = 0;
         end else begin
            if (hold_prev) begin
               chk("hold_data", out_data, prev_data);
               chk("hold_client", out_client, prev_client);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_beat data=%0h client=%0d expected none", out_data, out_client);
               end else begin
                  e = sb.pop_front();
                  chk("out_data", out_data, e.d);
                  chk("out_client", out_client, e.c);
               end
            end
            hold_prev   = out_valid && !out_ready;
            prev_data   = out_data;
            prev_client = out_client;
         end
      end
   end

   initial begin
      logic [CLIENTS-1:0]        v, g, rq;
      logic [CLIENTS*DATA_W-1:0] d;
      int                        idx;
      model_clear();
      do_reset(3);
      step('0, '0, '0, 1'b1);                  // in_ready still low this cycle
      step('0, '0, '0, 1'b1);                  // all slots ready now

      // Single push to client 3, grant while requesting.
      step(8'h08, dat1(3, 32'hA5), '0, 1'b1);
      step('0, '0, 8'h08, 1'b1);
      step('0, '0, '0, 1'b1);

      // Fill client 0, third push refused, drain in order.
      step(8'h01, dat1(0, 32'h11), '0, 1'b1);
      step(8'h01, dat1(0, 32'h22), '0, 1'b1);
      step(8'h01, dat1(0, 32'h33), '0, 1'b1);
      step('0, '0, 8'h01, 1'b1);
      step('0, '0, 8'h01, 1'b1);
      step('0, '0, '0, 1'b1);

      // Stall: hold output, grant under stall rejected.
      step(8'h24, dat1(2, 32'h2222) | dat1(5, 32'h5555), '0, 1'b0);
      step('0, '0, 8'h20, 1'b0);
      step('0, '0, '0, 1'b0);
      step('0, '0, 8'h04, 1'b0);
      step('0, '0, '0, 1'b0);
      step('0, '0, '0, 1'b1);
      step('0, '0, 8'h04, 1'b1);
      step('0, '0, '0, 1'b1);

      // Multi-hot grant, grant to an empty slot, then a legal push+pop at count 1.
      step(8'h06, dat1(1, 32'h101) | dat1(2, 32'h202), '0, 1'b1);
      step('0, '0, 8'h06, 1'b1);
      step('0, '0, 8'h20, 1'b1);
      step(8'h02, dat1(1, 32'h111), 8'h02, 1'b1);
      step('0, '0, 8'h04, 1'b1);
      step('0, '0, 8'h02, 1'b1);
      step('0, '0, '0, 1'b1);

      // Long wait on client 7.
      step(8'h80, dat1(7, 32'h77), '0, 1'b1);
      for (int k = 0; k < MAX_WAIT + 2; k++) step('0, '0, '0, 1'b1);
      step('0, '0, 8'h80, 1'b1);
      step('0, '0, '0, 1'b1);

      // Reset with two entries buffered in client 1; they must never appear.
      step(8'h02, dat1(1, 32'hDEAD0001), '0, 1'b1);
      step(8'h02, dat1(1, 32'hDEAD0002), '0, 1'b1);
      do_reset(1);
      step('0, '0, '0, 1'b1);
      step('0, '0, '0, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         v = CLIENTS'($urandom);
         for (int i = 0; i < CLIENTS; i++) d[i*DATA_W +: DATA_W] = $urandom;
         rq  = m_req();
         g   = '0;
         idx = $urandom_range(0, 9);
         if (idx == 0) begin
            g = CLIENTS'($urandom);
         end else if (idx < 7 && rq != 0) begin
            do idx = $urandom_range(0, CLIENTS - 1); while (!rq[idx]);
            g[idx] = 1'b1;
         end
         step(v, d, g, $urandom_range(0, 9) < 7);
      end

      for (int k = 0; k < 4; k++) step('0, '0, '0, 1'b1);
      chk("scoreboard_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
